// File: rtl/game_tick_pkg.sv
// Shared constants for the game tick generator: tile grid bounds
// and default widths/divisor for the per-channel frame dividers.
package game_tick_pkg;

    localparam int GRID_X_LAST = 39;
    localparam int GRID_Y_LAST = 29;

    localparam int COORD_W     = 10;
    localparam int DIV_W_DEF   = 4;
    localparam int FRAME_W_DEF = 16;

    localparam int DEFAULT_DIV = 6;

endpackage

// File: rtl/tick_channel.sv
// One frame-divider channel: counts advances and pulses tick
// once every div advances; div = 0 disables the channel.
module tick_channel #(
    parameter int DIV_W       = game_tick_pkg::DIV_W_DEF,
    parameter int DEFAULT_DIV = game_tick_pkg::DEFAULT_DIV
) (
    input  logic             in_clk,
    input  logic             reset,
    input  logic             advance,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_val,
    output logic             tick
);

    import game_tick_pkg::*;

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_ff @(posedge in_clk or negedge reset) begin
        if (!reset) begin
            div_q  <= DIV_W'(DEFAULT_DIV);
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    // A divisor write restarts the count and suppresses this frame's tick.
    always_comb begin
        div_d  = div_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (wr) begin
            div_d = wr_val;
            cnt_d = '0;
        end else if (advance && (div_q != '0)) begin
            if (cnt_q == div_q - 1'b1) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/game_tick_gen.sv
// Multi-channel game tick generator: detects frame ends on the tile
// scan, gates them with pause, and fans out to per-channel dividers.
module game_tick_gen #(
    parameter int X_W         = game_tick_pkg::COORD_W,
    parameter int Y_W         = game_tick_pkg::COORD_W,
    parameter int X_LAST      = game_tick_pkg::GRID_X_LAST,
    parameter int Y_LAST      = game_tick_pkg::GRID_Y_LAST,
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = game_tick_pkg::DIV_W_DEF,
    parameter int DEFAULT_DIV = game_tick_pkg::DEFAULT_DIV,
    parameter int FRAME_W     = game_tick_pkg::FRAME_W_DEF
) (
    input  logic               in_clk,
    input  logic               reset,
    input  logic [X_W-1:0]     x_in,
    input  logic [Y_W-1:0]     y_in,
    input  logic               pause,
    input  logic               div_wr,
    input  logic [2:0]         div_ch,
    input  logic [DIV_W-1:0]   div_val,
    output logic [NUM_CH-1:0]  tick,
    output logic [FRAME_W-1:0] frame_cnt
);

    import game_tick_pkg::*;

    logic               match;
    logic               match_q;
    logic               strobe_q;
    logic               advance;
    logic               wr_ok;
    logic [NUM_CH-1:0]  wr_sel;
    logic [FRAME_W-1:0] frame_q, frame_d;

    assign match = (x_in == X_W'(X_LAST)) && (y_in == Y_W'(Y_LAST));

    // match_q resets high so a scan parked on the last tile
    // at reset release is not mistaken for a new frame end.
    always_ff @(posedge in_clk or negedge reset) begin
        if (!reset) begin
            match_q  <= 1'b1;
            strobe_q <= 1'b0;
            frame_q  <= '0;
        end else begin
            match_q  <= match;
            strobe_q <= match && !match_q;
            frame_q  <= frame_d;
        end
    end

    assign advance = strobe_q && !pause;

    always_comb begin
        frame_d = frame_q;
        if (advance) begin
            frame_d = frame_q + 1'b1;
        end
    end

    assign wr_ok = div_wr && (32'(div_ch) < NUM_CH);

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = wr_ok && (div_ch == 3'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tick_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .in_clk  (in_clk),
            .reset   (reset),
            .advance (advance),
            .wr      (wr_sel[g]),
            .wr_val  (div_val),
            .tick    (tick[g])
        );
    end

    assign frame_cnt = frame_q;

endmodule

// File: tb/tb_game_tick_gen.sv
// Directed bench for game_tick_gen: frame division, pause,
// divisor writes, reset behaviour and out-of-range writes.
module tb_game_tick_gen;

    logic        clk;
    logic        rst_n;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        pause;
    logic        div_wr;
    logic [2:0]  div_ch;
    logic [3:0]  div_val;
    logic [3:0]  tick;
    logic [15:0] frame_cnt;

    int n_cmp = 0;
    int n_err = 0;

    game_tick_gen dut (
        .in_clk    (clk),
        .reset     (rst_n),
        .x_in      (x),
        .y_in      (y),
        .pause     (pause),
        .div_wr    (div_wr),
        .div_ch    (div_ch),
        .div_val   (div_val),
        .tick      (tick),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp,
                         input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check(32'(tick), 32'h0, "rst_tick");
        check(32'(frame_cnt), 32'h0, "rst_fcnt");
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wr_div(input logic [2:0] ch, input logic [3:0] val);
        div_wr  = 1'b1;
        div_ch  = ch;
        div_val = val;
        @(posedge clk);
        @(negedge clk);
        div_wr  = 1'b0;
    endtask

    // Holds (39,29) for three cycles; tick is expected only after edge k+1.
    task automatic frame(input logic p, input logic [3:0] exp,
                         input logic w, input string tag);
        pause = p;
        x = 10'd39;
        y = 10'd29;
        @(posedge clk);
        @(negedge clk);
        check(32'(tick), 32'h0, {tag, "_k"});
        if (w) begin
            div_wr  = 1'b1;
            div_ch  = 3'd0;
            div_val = 4'd6;
        end
        @(posedge clk);
        @(negedge clk);
        div_wr = 1'b0;
        check(32'(tick), 32'(exp), {tag, "_k1"});
        @(posedge clk);
        @(negedge clk);
        check(32'(tick), 32'h0, {tag, "_k2"});
        x = 10'd0;
        y = 10'd0;
        @(posedge clk);
        @(negedge clk);
        pause = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        x       = 10'd0;
        y       = 10'd0;
        pause   = 1'b0;
        div_wr  = 1'b0;
        div_ch  = 3'd0;
        div_val = 4'd0;

        // Defaults: all channels divide by 6.
        do_reset();
        for (int f = 1; f <= 13; f++)
            frame(1'b0, (f % 6 == 0) ? 4'hF : 4'h0, 1'b0, $sformatf("A%0d", f));
        check(32'(frame_cnt), 32'd13, "A_fcnt");

        // Mixed divisors: 6, 1, 0 (off), 3.
        wr_div(3'd0, 4'd6);
        wr_div(3'd1, 4'd1);
        wr_div(3'd2, 4'd0);
        wr_div(3'd3, 4'd3);
        frame(1'b0, 4'h2, 1'b0, "B1");
        frame(1'b0, 4'h2, 1'b0, "B2");
        frame(1'b0, 4'hA, 1'b0, "B3");
        frame(1'b0, 4'h2, 1'b0, "B4");
        frame(1'b0, 4'h2, 1'b0, "B5");
        frame(1'b0, 4'hB, 1'b0, "B6");
        check(32'(frame_cnt), 32'd19, "B_fcnt");

        // Pause across frames 3-5: strobes discarded, no catch-up.
        do_reset();
        frame(1'b0, 4'h0, 1'b0, "C1");
        frame(1'b0, 4'h0, 1'b0, "C2");
        frame(1'b1, 4'h0, 1'b0, "C3");
        frame(1'b1, 4'h0, 1'b0, "C4");
        frame(1'b1, 4'h0, 1'b0, "C5");
        check(32'(frame_cnt), 32'd2, "C_fcnt_paused");
        frame(1'b0, 4'h0, 1'b0, "C6");
        frame(1'b0, 4'h0, 1'b0, "C7");
        frame(1'b0, 4'h0, 1'b0, "C8");
        frame(1'b0, 4'hF, 1'b0, "C9");
        frame(1'b0, 4'h0, 1'b0, "C10");
        check(32'(frame_cnt), 32'd7, "C_fcnt");

        // Write to ch0 coinciding with the 6th advance wins over the tick.
        do_reset();
        for (int f = 1; f <= 5; f++)
            frame(1'b0, 4'h0, 1'b0, $sformatf("D%0d", f));
        frame(1'b0, 4'hE, 1'b1, "D6");
        for (int f = 7; f <= 11; f++)
            frame(1'b0, 4'h0, 1'b0, $sformatf("D%0d", f));
        frame(1'b0, 4'hF, 1'b0, "D12");

        // Reset released while parked on the last tile: no strobe.
        rst_n = 1'b0;
        x = 10'd39;
        y = 10'd29;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check(32'(tick), 32'h0, "E_park_tick");
        check(32'(frame_cnt), 32'h0, "E_park_fcnt");
        x = 10'd0;
        y = 10'd0;
        wr_div(3'd5, 4'd1);
        wr_div(3'd4, 4'd2);
        @(negedge clk);
        for (int f = 1; f <= 5; f++)
            frame(1'b0, 4'h0, 1'b0, $sformatf("E%0d", f));
        frame(1'b0, 4'hF, 1'b0, "E6");
        check(32'(frame_cnt), 32'd6, "E_fcnt");

        // Async reset drops a pending tick and restores default divisors.
        do_reset();
        wr_div(3'd1, 4'd2);
        frame(1'b0, 4'h0, 1'b0, "F1");
        frame(1'b0, 4'h2, 1'b0, "F2");
        frame(1'b0, 4'h0, 1'b0, "F3");
        x = 10'd39;
        y = 10'd29;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        check(32'(tick), 32'h2, "F4_pre");
        #1 rst_n = 1'b0;
        #1;
        check(32'(tick), 32'h0, "F4_async_tick");
        check(32'(frame_cnt), 32'h0, "F4_async_fcnt");
        @(negedge clk);
        x = 10'd0;
        y = 10'd0;
        rst_n = 1'b1;
        @(negedge clk);
        for (int f = 1; f <= 5; f++)
            frame(1'b0, 4'h0, 1'b0, $sformatf("G%0d", f));
        frame(1'b0, 4'hF, 1'b0, "G6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
